// File: rtl/music_pkg.sv
// Shared definitions for the score playback engine: entry layout, FSM states
// and the note-code to note_gen divider table.
package music_pkg;

    localparam int ENTRY_W    = 13;
    localparam int TIE_BIT    = 12;
    localparam int CODE_L_LSB = 6;
    localparam int CODE_R_LSB = 0;
    localparam int CODE_W     = 6;

    localparam logic [CODE_W-1:0] CODE_REST  = 6'd0;
    localparam logic [21:0]       DIV_SILENT = 22'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic tie,
                                                    input logic [CODE_W-1:0] code_l,
                                                    input logic [CODE_W-1:0] code_r);
        return {tie, code_l, code_r};
    endfunction

    // Divider = round(50 MHz / f) - 1; code 1 is C3, code 48 is B6. Rest and
    // unused codes map to the silent divider.
    function automatic logic [21:0] note_div(input logic [CODE_W-1:0] code);
        logic [21:0] d;
        case (code)
            6'd1:  d = 22'd382225;  6'd2:  d = 22'd360772;  6'd3:  d = 22'd340523;  6'd4:  d = 22'd321411;
            6'd5:  d = 22'd303372;  6'd6:  d = 22'd286345;  6'd7:  d = 22'd270273;  6'd8:  d = 22'd255104;
            6'd9:  d = 22'd240786;  6'd10: d = 22'd227272;  6'd11: d = 22'd214516;  6'd12: d = 22'd202476;
            6'd13: d = 22'd191112;  6'd14: d = 22'd180385;  6'd15: d = 22'd170261;  6'd16: d = 22'd160705;
            6'd17: d = 22'd151685;  6'd18: d = 22'd143172;  6'd19: d = 22'd135136;  6'd20: d = 22'd127552;
            6'd21: d = 22'd120393;  6'd22: d = 22'd113635;  6'd23: d = 22'd107257;  6'd24: d = 22'd101237;
            6'd25: d = 22'd95555;   6'd26: d = 22'd90192;   6'd27: d = 22'd85130;   6'd28: d = 22'd80352;
            6'd29: d = 22'd75842;   6'd30: d = 22'd71585;   6'd31: d = 22'd67568;   6'd32: d = 22'd63775;
            6'd33: d = 22'd60196;   6'd34: d = 22'd56817;   6'd35: d = 22'd53628;   6'd36: d = 22'd50618;
            6'd37: d = 22'd47777;   6'd38: d = 22'd45096;   6'd39: d = 22'd42565;   6'd40: d = 22'd40176;
            6'd41: d = 22'd37921;   6'd42: d = 22'd35792;   6'd43: d = 22'd33783;   6'd44: d = 22'd31887;
            6'd45: d = 22'd30097;   6'd46: d = 22'd28408;   6'd47: d = 22'd26814;   6'd48: d = 22'd25309;
            default: d = DIV_SILENT;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/music_rom.sv
// Fixed score, one 13-bit entry {tie, code_l, code_r} per beat, with a
// registered (1-cycle) read. Unlisted addresses hold rests.
module music_rom
    import music_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    logic [ENTRY_W-1:0] entry;

    always_comb begin
        entry = mk_entry(1'b0, CODE_REST, CODE_REST);
        case (int'(addr))
            0:  entry = mk_entry(1'b0, 6'd22, 6'd22);
            1:  entry = mk_entry(1'b1, 6'd13, CODE_REST);
            2:  entry = mk_entry(1'b0, CODE_REST, CODE_REST);
            3:  entry = mk_entry(1'b0, 6'd22, 6'd13);
            4:  entry = mk_entry(1'b0, 6'd17, 6'd1);
            5:  entry = mk_entry(1'b0, 6'd17, 6'd1);
            6:  entry = mk_entry(1'b0, 6'd18, 6'd8);
            7:  entry = mk_entry(1'b0, 6'd20, 6'd8);
            8:  entry = mk_entry(1'b0, 6'd20, 6'd1);
            9:  entry = mk_entry(1'b0, 6'd18, 6'd1);
            10: entry = mk_entry(1'b0, 6'd17, 6'd8);
            11: entry = mk_entry(1'b0, 6'd15, 6'd8);
            12: entry = mk_entry(1'b0, 6'd13, 6'd1);
            13: entry = mk_entry(1'b0, 6'd13, 6'd1);
            14: entry = mk_entry(1'b0, 6'd15, 6'd8);
            15: entry = mk_entry(1'b0, 6'd17, 6'd8);
            16: entry = mk_entry(1'b1, 6'd17, 6'd1);
            17: entry = mk_entry(1'b0, 6'd15, 6'd1);
            18: entry = mk_entry(1'b1, 6'd15, 6'd8);
            19: entry = mk_entry(1'b0, 6'd15, 6'd8);
            default: entry = mk_entry(1'b0, CODE_REST, CODE_REST);
        endcase
    end

    always_ff @(posedge clk) begin
        data <= entry;
    end

endmodule

// File: rtl/music_sequencer.sv
// Score playback engine feeding note_gen: beat timing FSM, score ROM read,
// and a two-stage code-to-divider path with articulation gaps.
module music_sequencer
    import music_pkg::*;
#(
    parameter int BEAT_DIV = 25_000_000,
    parameter int GAP      = 2_000_000,
    parameter int LEN      = 128,
    parameter int ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [1:0]        speed,
    output logic [21:0]       note_div_left,
    output logic [21:0]       note_div_right,
    output logic [ADDR_W-1:0] beat_idx,
    output logic              playing,
    output logic              done,
    output state_e            dbg_state_o
);

    localparam logic [24:0]       BEAT_DIV_W = 25'(BEAT_DIV);
    localparam logic [24:0]       GAP_W      = 25'(GAP);
    localparam logic [ADDR_W-1:0] LAST_BEAT  = ADDR_W'(LEN - 1);

    state_e              state_q;
    logic [24:0]         tick_q;
    logic [24:0]         beat_len_q;
    logic [ADDR_W-1:0]   beat_q;
    logic                playing_q;
    logic                done_q;
    logic                play_d1_q;
    logic                gap_d1_q;
    logic [21:0]         div_l_q;
    logic [21:0]         div_r_q;
    logic [ENTRY_W-1:0]  rom_data;

    logic [24:0] beat_len_cur;
    logic        last_tick;
    logic        last_beat;
    logic        in_gap;

    // The new tempo is picked up at tick 0, so the whole beat uses one length.
    always_comb begin
        beat_len_cur = (tick_q == '0) ? (BEAT_DIV_W >> speed) : beat_len_q;
        last_tick    = (tick_q == beat_len_cur - 25'd1);
        last_beat    = (beat_q == LAST_BEAT);
        in_gap       = (tick_q >= beat_len_cur - GAP_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            beat_len_q <= BEAT_DIV_W;
            beat_q     <= '0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tick_q == '0) begin
                beat_len_q <= beat_len_cur;
            end
            case (state_q)
                IDLE: begin
                    if (play_pause && !stop) begin
                        state_q   <= PLAY;
                        playing_q <= 1'b1;
                        tick_q    <= '0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        playing_q <= 1'b0;
                        tick_q    <= '0;
                        beat_q    <= '0;
                    end else if (last_tick && last_beat) begin
                        tick_q <= '0;
                        beat_q <= '0;
                        if (!loop_en) begin
                            state_q   <= IDLE;
                            playing_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else if (play_pause) begin
                        state_q   <= PAUSE;
                        playing_q <= 1'b0;
                    end else if (last_tick) begin
                        tick_q <= '0;
                        beat_q <= beat_q + ADDR_W'(1);
                    end else begin
                        tick_q <= tick_q + 25'd1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                        beat_q  <= '0;
                    end else if (play_pause) begin
                        state_q   <= PLAY;
                        playing_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    playing_q <= 1'b0;
                    tick_q    <= '0;
                    beat_q    <= '0;
                end
            endcase
        end
    end

    music_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk  (clk),
        .addr (beat_q),
        .data (rom_data)
    );

    // Play/gap flags are delayed one cycle to line up with the ROM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            play_d1_q <= 1'b0;
            gap_d1_q  <= 1'b0;
            div_l_q   <= DIV_SILENT;
            div_r_q   <= DIV_SILENT;
        end else begin
            play_d1_q <= (state_q == PLAY);
            gap_d1_q  <= in_gap;
            if (play_d1_q && !(gap_d1_q && !rom_data[TIE_BIT])) begin
                div_l_q <= note_div(rom_data[CODE_L_LSB +: CODE_W]);
                div_r_q <= note_div(rom_data[CODE_R_LSB +: CODE_W]);
            end else begin
                div_l_q <= DIV_SILENT;
                div_r_q <= DIV_SILENT;
            end
        end
    end

    assign note_div_left  = div_l_q;
    assign note_div_right = div_r_q;
    assign beat_idx       = beat_q;
    assign playing        = playing_q;
    assign done           = done_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer with a 4-entry, 16-cycle-beat configuration:
// directed scenarios followed by random button/tempo/loop activity.
module tb_music_sequencer;
    import music_pkg::*;

    localparam int A4  = 113635;
    localparam int C4  = 191112;
    localparam int SIL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        play_pause = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic [21:0] note_div_left;
    logic [21:0] note_div_right;
    logic [6:0]  beat_idx;
    logic        playing;
    logic        done;
    state_e      dbg_state;

    int checks = 0;
    int failures = 0;

    music_sequencer #(.BEAT_DIV(16), .GAP(2), .LEN(4), .ADDR_W(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .play_pause     (play_pause),
        .stop           (stop),
        .loop_en        (loop_en),
        .speed          (speed),
        .note_div_left  (note_div_left),
        .note_div_right (note_div_right),
        .beat_idx       (beat_idx),
        .playing        (playing),
        .done           (done),
        .dbg_state_o    (dbg_state)
    );

    always #5 clk = ~clk;

    // Score as the test plan describes it, already mapped to dividers.
    int rom_l[4]   = '{A4, C4, SIL, A4};
    int rom_r[4]   = '{A4, SIL, SIL, C4};
    bit rom_tie[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    // Reference model: running/paused flags, position in the score, the
    // length of the current beat and a one-deep queue of pending outputs.
    bit m_on, m_paused, m_done;
    int m_tick, m_beat, m_len;
    int m_pend_l, m_pend_r, m_exp_l, m_exp_r;

    task automatic model_reset();
        m_on = 0; m_paused = 0; m_done = 0;
        m_tick = 0; m_beat = 0; m_len = 16;
        m_pend_l = SIL; m_pend_r = SIL; m_exp_l = SIL; m_exp_r = SIL;
    endtask

    task automatic model_step(input bit pp, input bit st);
        int cur_len;
        bit sounding;
        cur_len = (m_tick == 0) ? (16 >> speed) : m_len;
        m_exp_l = m_pend_l;
        m_exp_r = m_pend_r;
        sounding = m_on && !m_paused && (rom_tie[m_beat] || m_tick < cur_len - 2);
        m_pend_l = sounding ? rom_l[m_beat] : SIL;
        m_pend_r = sounding ? rom_r[m_beat] : SIL;
        m_len = cur_len;
        m_done = 0;
        if (!m_on) begin
            if (pp && !st) begin
                m_on = 1; m_paused = 0; m_tick = 0;
            end
        end else if (st) begin
            m_on = 0; m_paused = 0; m_tick = 0; m_beat = 0;
        end else if (m_paused) begin
            if (pp) m_paused = 0;
        end else if (m_tick == cur_len - 1 && m_beat == 3) begin
            m_tick = 0; m_beat = 0;
            if (!loop_en) begin
                m_on = 0; m_done = 1;
            end
        end else if (pp) begin
            m_paused = 1;
        end else if (m_tick == cur_len - 1) begin
            m_tick = 0; m_beat = m_beat + 1;
        end else begin
            m_tick = m_tick + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        state_e exp_state;
        exp_state = !m_on ? IDLE : (m_paused ? PAUSE : PLAY);
        chk("div_left", 32'(note_div_left), 32'(m_exp_l));
        chk("div_right", 32'(note_div_right), 32'(m_exp_r));
        chk("beat_idx", 32'(beat_idx), 32'(m_beat));
        chk("playing", 32'(playing), 32'(m_on && !m_paused));
        chk("done", 32'(done), 32'(m_done));
        chk("state", 32'(dbg_state), 32'(exp_state));
    endtask

    task automatic cycle(input bit pp, input bit st);
        play_pause = pp;
        stop = st;
        @(posedge clk);
        model_step(pp, st);
        @(negedge clk);
        play_pause = 1'b0;
        stop = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        play_pause = 1'b0;
        stop = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        bit pp, st;
        @(negedge clk);

        // Reset values, start, first note, gap and beat advance.
        do_reset();
        chk("reset_left", 32'(note_div_left), SIL);
        chk("reset_playing", 32'(playing), 0);
        cycle(1, 0);
        chk("start_playing", 32'(playing), 1);
        cycle(0, 0); cycle(0, 0);
        chk("first_note_l", 32'(note_div_left), A4);
        chk("first_note_r", 32'(note_div_right), A4);
        repeat (13) cycle(0, 0);
        chk("beat0_len", 32'(beat_idx), 0);
        cycle(0, 0);
        chk("beat1_start", 32'(beat_idx), 1);
        chk("gap_silence", 32'(note_div_left), SIL);

        // Tied entry holds C4 across the whole beat.
        cycle(0, 0); cycle(0, 0);
        chk("tied_first", 32'(note_div_left), C4);
        repeat (15) cycle(0, 0);
        chk("tied_last_l", 32'(note_div_left), C4);
        chk("tied_last_r", 32'(note_div_right), SIL);

        // End of score without looping.
        repeat (31) cycle(0, 0);
        chk("end_done", 32'(done), 1);
        chk("end_state", 32'(dbg_state), 32'(IDLE));
        chk("end_beat", 32'(beat_idx), 0);
        cycle(0, 0);
        chk("done_one_cycle", 32'(done), 0);
        cycle(0, 0); cycle(0, 0);
        chk("end_silent", 32'(note_div_left), SIL);

        // Looping: wrap from entry 3 to 0 without a done pulse.
        loop_en = 1'b1;
        cycle(1, 0);
        repeat (63) cycle(0, 0);
        chk("loop_beat3", 32'(beat_idx), 3);
        cycle(0, 0);
        chk("loop_wrap", 32'(beat_idx), 0);
        chk("loop_playing", 32'(playing), 1);
        chk("loop_no_done", 32'(done), 0);
        cycle(0, 1);
        chk("stop_idle", 32'(dbg_state), 32'(IDLE));

        // Pause at tick 5 of beat 1 for 100 cycles, then resume.
        cycle(1, 0);
        repeat (21) cycle(0, 0);
        cycle(1, 0);
        chk("pause_state", 32'(dbg_state), 32'(PAUSE));
        repeat (100) cycle(0, 0);
        chk("pause_beat", 32'(beat_idx), 1);
        chk("pause_silent", 32'(note_div_left), SIL);
        cycle(1, 0);
        repeat (10) cycle(0, 0);
        chk("resume_beat1", 32'(beat_idx), 1);
        cycle(0, 0);
        chk("resume_beat2", 32'(beat_idx), 2);

        // Tempo change mid-beat only affects the next beat.
        repeat (3) cycle(0, 0);
        speed = 2'd1;
        repeat (12) cycle(0, 0);
        chk("speed_old_len", 32'(beat_idx), 2);
        cycle(0, 0);
        chk("speed_beat3", 32'(beat_idx), 3);
        repeat (7) cycle(0, 0);
        chk("speed_new_len", 32'(beat_idx), 3);
        cycle(0, 0);
        chk("speed_wrap", 32'(beat_idx), 0);
        cycle(1, 1);
        chk("stop_wins", 32'(dbg_state), 32'(IDLE));
        chk("stop_wins_play", 32'(playing), 0);
        speed = 2'd0;

        // Reset in the middle of beat 2, then a clean restart.
        cycle(1, 0);
        repeat (37) cycle(0, 0);
        do_reset();
        chk("rst_mid_l", 32'(note_div_left), SIL);
        chk("rst_mid_beat", 32'(beat_idx), 0);
        chk("rst_mid_playing", 32'(playing), 0);
        cycle(1, 0); cycle(0, 0); cycle(0, 0);
        chk("restart_note", 32'(note_div_left), A4);
        chk("restart_beat", 32'(beat_idx), 0);

        // Random buttons, tempo, loop mode and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            pp = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            if ($urandom_range(0, 499) == 0) do_reset();
            else cycle(pp, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
